// File: rtl/mul_div_if.sv
// Bus between the E-stage datapath/hazard unit and the multiply/divide unit.
// The master drives the E/D-stage request side; the slave is the unit itself.
interface mul_div_if;
    logic [2:0]  md_op_E;
    logic        md_rd_E;
    logic [31:0] A_E;
    logic [31:0] B_E;
    logic        cancel_E;
    logic        md_use_D;
    logic        busy;
    logic        start;
    logic        stall_md;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] rd_data;

    modport master (
        output md_op_E, md_rd_E, A_E, B_E, cancel_E, md_use_D,
        input  busy, start, stall_md, HI, LO, rd_data
    );

    modport slave (
        input  md_op_E, md_rd_E, A_E, B_E, cancel_E, md_use_D,
        output busy, start, stall_md, HI, LO, rd_data
    );
endinterface

// File: rtl/mul_div_unit.sv
// Multi-cycle multiply/divide unit owning the HI/LO registers.
// The result is computed at start into holding registers and committed to
// HI/LO when the fixed-latency countdown expires, so the architectural
// registers never show a partial value.
module mul_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic     clk,
    input  logic     reset,
    mul_div_if.slave md
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MULT = 2'd1;
    localparam logic [1:0] ST_DIV  = 2'd2;

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    logic [1:0]  state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        busy_q, busy_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] res_hi_q, res_hi_d;
    logic [31:0] res_lo_q, res_lo_d;
    logic        nowr_q, nowr_d;     // divide by zero: skip the HI/LO commit

    logic        start_s;
    logic [63:0] mul_res_s;
    logic [63:0] div_res_s;

    // 64-bit product; sign extension is applied only for the signed variant.
    function automatic logic [63:0] mul_calc(input logic [31:0] a,
                                             input logic [31:0] b,
                                             input logic        sgn);
        logic [63:0] a64;
        logic [63:0] b64;
        a64 = {{32{sgn & a[31]}}, a};
        b64 = {{32{sgn & b[31]}}, b};
        return a64 * b64;
    endfunction

    // Returns {remainder, quotient}. Signed division works on magnitudes, so
    // 0x80000000 / -1 naturally yields quotient 0x80000000, remainder 0.
    function automatic logic [63:0] div_calc(input logic [31:0] a,
                                             input logic [31:0] b,
                                             input logic        sgn);
        logic        a_neg;
        logic        b_neg;
        logic [31:0] a_mag;
        logic [31:0] b_mag;
        logic [31:0] q;
        logic [31:0] r;
        a_neg = sgn & a[31];
        b_neg = sgn & b[31];
        a_mag = a_neg ? (32'd0 - a) : a;
        b_mag = b_neg ? (32'd0 - b) : b;
        if (b_mag == 32'd0) begin
            q = 32'd0;
            r = 32'd0;
        end else begin
            q = a_mag / b_mag;
            r = a_mag % b_mag;
        end
        if (a_neg ^ b_neg) begin
            q = 32'd0 - q;
        end else begin
            q = q;
        end
        if (a_neg) begin
            r = 32'd0 - r;
        end else begin
            r = r;
        end
        return {r, q};
    endfunction

    // Start decode: a multiply/divide op in E that is not being cancelled.
    always_comb begin
        start_s = 1'b0;
        if (!md.cancel_E && (md.md_op_E >= OP_MULT) && (md.md_op_E <= OP_DIVU)) begin
            start_s = 1'b1;
        end else begin
            start_s = 1'b0;
        end
    end

    // Next-state logic: op launch, countdown, HI/LO commit and mthi/mtlo writes.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        res_hi_d  = res_hi_q;
        res_lo_d  = res_lo_q;
        nowr_d    = nowr_q;
        mul_res_s = mul_calc(md.A_E, md.B_E, md.md_op_E == OP_MULT);
        div_res_s = div_calc(md.A_E, md.B_E, md.md_op_E == OP_DIV);
        case (state_q)
            ST_IDLE: begin
                if (start_s) begin
                    busy_d = 1'b1;
                    if ((md.md_op_E == OP_MULT) || (md.md_op_E == OP_MULTU)) begin
                        state_d  = ST_MULT;
                        cnt_d    = 8'(MULT_CYCLES);
                        res_hi_d = mul_res_s[63:32];
                        res_lo_d = mul_res_s[31:0];
                        nowr_d   = 1'b0;
                    end else begin
                        state_d  = ST_DIV;
                        cnt_d    = 8'(DIV_CYCLES);
                        res_hi_d = div_res_s[63:32];
                        res_lo_d = div_res_s[31:0];
                        nowr_d   = (md.B_E == 32'd0);
                    end
                end else if (!md.cancel_E && (md.md_op_E == OP_MTHI)) begin
                    hi_d = md.A_E;
                end else if (!md.cancel_E && (md.md_op_E == OP_MTLO)) begin
                    lo_d = md.A_E;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MULT, ST_DIV: begin
                // Ops arriving while busy are ignored; cancel does not abort.
                if (cnt_q <= 8'd1) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    cnt_d   = 8'd0;
                    if (!nowr_q) begin
                        hi_d = res_hi_q;
                        lo_d = res_lo_q;
                    end else begin
                        hi_d = hi_q;
                        lo_d = lo_q;
                    end
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                cnt_d   = 8'd0;
            end
        endcase
    end

    // State registers; reset discards any pending result and clears HI/LO.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 8'd0;
            busy_q   <= 1'b0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            res_hi_q <= 32'd0;
            res_lo_q <= 32'd0;
            nowr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            res_hi_q <= res_hi_d;
            res_lo_q <= res_lo_d;
            nowr_q   <= nowr_d;
        end
    end

    assign md.busy     = busy_q;
    assign md.start    = start_s;
    assign md.stall_md = md.md_use_D & (busy_q | start_s);
    assign md.HI       = hi_q;
    assign md.LO       = lo_q;
    assign md.rd_data  = md.md_rd_E ? lo_q : hi_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: expected HI/LO pairs go into a scoreboard
// queue when an op is issued and are popped when the unit finishes.
module tb_mul_div_unit;

    logic clk;
    logic reset;
    int   n_cmp = 0;
    int   n_bad = 0;
    logic [63:0] sb_q[$];
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    mul_div_if bus();

    mul_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .md    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue an op this cycle, walk the N busy cycles, then check the commit.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int n, input logic use_d,
                          input logic [31:0] ehi, input logic [31:0] elo, input bit poke);
        logic [63:0] e;
        sb_q.push_back({ehi, elo});
        bus.md_op_E  = op;
        bus.A_E      = a;
        bus.B_E      = b;
        bus.cancel_E = 1'b0;
        bus.md_use_D = use_d;
        #1;
        chk("start_t", {31'd0, bus.start}, 32'd1);
        chk("stall_t", {31'd0, bus.stall_md}, {31'd0, use_d});
        for (int k = 1; k <= n; k++) begin
            step();
            bus.md_op_E = (poke && k == 2) ? 3'd5 : 3'd0;
            bus.A_E     = 32'hDEAD_BEEF;
            #1;
            chk("busy_run", {31'd0, bus.busy}, 32'd1);
            chk("stall_run", {31'd0, bus.stall_md}, {31'd0, use_d});
            chk("hi_hold", bus.HI, m_hi);
            chk("lo_hold", bus.LO, m_lo);
        end
        step();
        bus.md_op_E = 3'd0;
        #1;
        chk("busy_done", {31'd0, bus.busy}, 32'd0);
        chk("stall_done", {31'd0, bus.stall_md}, 32'd0);
        e = sb_q.pop_front();
        m_hi = e[63:32];
        m_lo = e[31:0];
        chk("hi_result", bus.HI, m_hi);
        chk("lo_result", bus.LO, m_lo);
        bus.md_rd_E = 1'b0;
        #1;
        chk("rd_mfhi", bus.rd_data, m_hi);
        bus.md_rd_E = 1'b1;
        #1;
        chk("rd_mflo", bus.rd_data, m_lo);
        bus.md_rd_E = 1'b0;
    endtask

    // mthi/mtlo with optional cancel; HI/LO checked the following cycle.
    task automatic mt(input logic [2:0] op, input logic [31:0] a, input logic c);
        bus.md_op_E  = op;
        bus.A_E      = a;
        bus.cancel_E = c;
        #1;
        chk("mt_start", {31'd0, bus.start}, 32'd0);
        step();
        bus.md_op_E  = 3'd0;
        bus.cancel_E = 1'b0;
        #1;
        if (!c && op == 3'd5) m_hi = a;
        if (!c && op == 3'd6) m_lo = a;
        chk("mt_busy", {31'd0, bus.busy}, 32'd0);
        chk("mt_hi", bus.HI, m_hi);
        chk("mt_lo", bus.LO, m_lo);
    endtask

    initial begin
        reset        = 1'b0;
        bus.md_op_E  = 3'd0;
        bus.md_rd_E  = 1'b0;
        bus.A_E      = 32'd0;
        bus.B_E      = 32'd0;
        bus.cancel_E = 1'b0;
        bus.md_use_D = 1'b1;
        m_hi = 32'd0;
        m_lo = 32'd0;
        repeat (2) step();
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_hi", bus.HI, 32'd0);
        chk("rst_lo", bus.LO, 32'd0);
        chk("rst_rd", bus.rd_data, 32'd0);
        chk("rst_stall", {31'd0, bus.stall_md}, 32'd0);
        reset = 1'b1;
        step();

        // Consecutive run_op calls issue back-to-back in the idle cycle.
        run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 1'b1, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        run_op(3'd1, 32'hFFFF_FFFD, 32'h0000_0005, 5, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b1);
        run_op(3'd3, 32'hFFFF_FFF9, 32'h0000_0002, 10, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        run_op(3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 10, 1'b1, 32'h0000_0001, 32'h7FFF_FFFC, 1'b0);
        run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10, 1'b1, 32'h0000_0000, 32'h8000_0000, 1'b0);
        run_op(3'd1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 5, 1'b1, 32'h3FFF_FFFF, 32'h0000_0001, 1'b0);

        // Cancelled mult: nothing starts, HI/LO unchanged.
        bus.md_op_E  = 3'd1;
        bus.A_E      = 32'd3;
        bus.B_E      = 32'd4;
        bus.cancel_E = 1'b1;
        bus.md_use_D = 1'b1;
        #1;
        chk("cancel_start", {31'd0, bus.start}, 32'd0);
        chk("cancel_stall", {31'd0, bus.stall_md}, 32'd0);
        step();
        bus.md_op_E  = 3'd0;
        bus.cancel_E = 1'b0;
        #1;
        chk("cancel_busy", {31'd0, bus.busy}, 32'd0);
        chk("cancel_hi", bus.HI, m_hi);
        chk("cancel_lo", bus.LO, m_lo);

        mt(3'd5, 32'h0000_1234, 1'b1);
        mt(3'd5, 32'h0000_1234, 1'b0);
        mt(3'd5, 32'h0000_AAAA, 1'b0);
        mt(3'd6, 32'h0000_5555, 1'b0);
        // Divide by zero: full latency, HI/LO preserved.
        run_op(3'd3, 32'h0000_1234, 32'h0000_0000, 10, 1'b1, 32'h0000_AAAA, 32'h0000_5555, 1'b0);

        // Reset in the third busy cycle of a div.
        bus.md_op_E = 3'd3;
        bus.A_E     = 32'd100;
        bus.B_E     = 32'd7;
        for (int k = 1; k <= 3; k++) begin
            step();
            bus.md_op_E = 3'd0;
        end
        #1;
        chk("pre_rst_busy", {31'd0, bus.busy}, 32'd1);
        reset = 1'b0;
        #1;
        chk("async_busy", {31'd0, bus.busy}, 32'd0);
        chk("async_hi", bus.HI, 32'd0);
        chk("async_lo", bus.LO, 32'd0);
        m_hi = 32'd0;
        m_lo = 32'd0;
        repeat (2) step();
        reset = 1'b1;
        for (int k = 0; k < 12; k++) begin
            step();
            chk("post_rst_busy", {31'd0, bus.busy}, 32'd0);
            chk("post_rst_hi", bus.HI, 32'd0);
            chk("post_rst_lo", bus.LO, 32'd0);
        end
        chk("sb_empty", sb_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
